// File: rtl/branch_predict_unit_if.sv
// Fetch/resolve bus between the core pipeline and the branch predictor.
// The master side (core) drives the IF fetch PC and the ID resolution
// fields; the slave side (predictor) answers with the prediction, the
// flush request and the optional performance counters.
interface branch_predict_unit_if #(
    parameter int DATA_W = 64
);
    // IF-stage lookup
    logic [DATA_W-1:0] fetch_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [DATA_W-1:0] pred_target;

    // ID-stage resolution
    logic              upd_valid;
    logic [DATA_W-1:0] upd_pc;
    logic              upd_is_jump;
    logic              upd_taken;
    logic [DATA_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [DATA_W-1:0] upd_pred_target;
    logic              mispredict;
    logic [DATA_W-1:0] redirect_pc;

    // Performance counters
    logic [31:0]       perf_updates;
    logic [31:0]       perf_mispredicts;

    modport master (
        output fetch_pc,
        input  pred_hit, pred_taken, pred_target,
        output upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target,
        input  mispredict, redirect_pc,
        input  perf_updates, perf_mispredicts
    );

    modport slave (
        input  fetch_pc,
        output pred_hit, pred_taken, pred_target,
        input  upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target,
        output mispredict, redirect_pc,
        output perf_updates, perf_mispredicts
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: direct-mapped BHT of saturating counters plus
// a tagged BTB. Lookup (IF) is combinational; training (ID) happens on the
// clock edge and becomes visible to lookups one cycle later, with no bypass.
// Optional macro BPU_PERF_CNT_EN adds saturating update/mispredict counters;
// without it the perf outputs are tied to zero and no counter flops exist.
module branch_predict_unit #(
    parameter int DATA_W  = 64,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    branch_predict_unit_if.slave  bus
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

    // Entry storage: valid bits and counters carry reset, tag/target do not
    logic [ENTRIES-1:0] valid;
    logic [CNT_W-1:0]   cnt     [ENTRIES];
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [DATA_W-1:0]  tgt_mem [ENTRIES];

    // Lookup side
    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic [DATA_W-1:0] f_seq_pc;
    logic              f_hit;
    logic              f_taken;

    assign f_idx    = bus.fetch_pc[IDX_W+1:2];
    assign f_tag    = bus.fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign f_seq_pc = bus.fetch_pc + PC_STEP;

    // Combinational prediction from the pre-update array contents
    always_comb begin
        f_hit   = valid[f_idx] && (tag_mem[f_idx] == f_tag);
        f_taken = f_hit && cnt[f_idx][CNT_W-1];
    end

    assign bus.pred_hit    = f_hit;
    assign bus.pred_taken  = f_taken;
    assign bus.pred_target = f_taken ? tgt_mem[f_idx] : f_seq_pc;

    // Resolution side
    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;
    logic [DATA_W-1:0] u_seq_pc;
    logic              u_hit;
    logic              u_taken;
    logic              u_fire;
    logic              misp;

    assign u_idx    = bus.upd_pc[IDX_W+1:2];
    assign u_tag    = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_seq_pc = bus.upd_pc + PC_STEP;
    assign u_fire   = enable && bus.upd_valid;
    // Jumps always train as taken even if the pipe reports otherwise
    assign u_taken  = bus.upd_taken || bus.upd_is_jump;

    // Flush request and corrected fetch PC, independent of enable
    always_comb begin
        misp = bus.upd_valid &&
               ((bus.upd_taken != bus.upd_pred_taken) ||
                (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
    end

    assign bus.mispredict  = misp;
    assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : u_seq_pc;

    // Training decision: counter step on hit, allocation on taken miss
    logic             alloc;
    logic             cnt_we;
    logic             tgt_we;
    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        alloc   = 1'b0;
        cnt_we  = 1'b0;
        tgt_we  = 1'b0;
        u_hit   = valid[u_idx] && (tag_mem[u_idx] == u_tag);
        cnt_cur = cnt[u_idx];
        cnt_nxt = cnt_cur;
        if (u_fire) begin
            if (u_hit) begin
                cnt_we = 1'b1;
                tgt_we = u_taken;
                if (bus.upd_is_jump) begin
                    cnt_nxt = CNT_MAX;
                end else if (u_taken) begin
                    if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_W'(1);
                end else begin
                    if (cnt_cur != '0) cnt_nxt = cnt_cur - CNT_W'(1);
                end
            end else if (u_taken) begin
                alloc   = 1'b1;
                cnt_we  = 1'b1;
                tgt_we  = 1'b1;
                cnt_nxt = bus.upd_is_jump ? CNT_MAX : CNT_WEAK_T;
            end
        end
    end

    // Valid bits and counters; reset clears everything and drops the update
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt[i] <= CNT_WEAK_NT;
            end
        end else begin
            if (alloc) valid[u_idx] <= 1'b1;
            if (cnt_we) cnt[u_idx] <= cnt_nxt;
        end
    end

    // Tag and target payload; contents are meaningless while valid is low,
    // so a write landing during reset is harmless
    always_ff @(posedge clk) begin
        if (alloc) tag_mem[u_idx] <= u_tag;
        if (tgt_we) tgt_mem[u_idx] <= bus.upd_target;
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_upd_q;
    logic [31:0] perf_misp_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            perf_upd_q  <= '0;
            perf_misp_q <= '0;
        end else begin
            if (u_fire && (perf_upd_q != '1)) perf_upd_q <= perf_upd_q + 32'd1;
            if (misp && enable && (perf_misp_q != '1)) perf_misp_q <= perf_misp_q + 32'd1;
        end
    end

    assign bus.perf_updates     = perf_upd_q;
    assign bus.perf_mispredicts = perf_misp_q;
`else
    assign bus.perf_updates     = '0;
    assign bus.perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (ENTRIES=64, CNT_W=2, TAG_W=8).
// Directed table of scenarios, an asynchronous reset pulse, then randomized
// traffic compared against an array-based reference model.
module tb_branch_predict_unit;

    localparam int DATA_W  = 64;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;
    localparam int TAG_W   = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int CHALF   = 1 << (CNT_W - 1);

    logic clk;
    logic arst_n;
    logic enable;

    branch_predict_unit_if #(.DATA_W(DATA_W)) bus ();

    branch_predict_unit #(
        .DATA_W (DATA_W),
        .ENTRIES(ENTRIES),
        .CNT_W  (CNT_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .enable(enable),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid [ENTRIES];
    logic [7:0]  m_tag   [ENTRIES];
    logic [63:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    int          m_perf_upd;
    int          m_perf_misp;

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [7:0] tag_of(input logic [63:0] pc);
        logic [63:0] t;
        t = (pc >> 8) & 64'hFF;
        return t[7:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = CHALF - 1;
        end
        m_perf_upd  = 0;
        m_perf_misp = 0;
    endtask

    task automatic model_predict(input logic [63:0] pc, output logic hit,
                                 output logic tk, output logic [63:0] tgt);
        int i;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        tk  = hit && (m_cnt[i] >= CHALF);
        tgt = tk ? m_tgt[i] : pc + 64'd4;
    endtask

    function automatic logic model_misp();
        if (!bus.upd_valid) return 1'b0;
        if (bus.upd_taken != bus.upd_pred_taken) return 1'b1;
        return bus.upd_taken && (bus.upd_target != bus.upd_pred_target);
    endfunction

    task automatic model_update();
        int   i;
        logic tk;
        if (enable && bus.upd_valid) begin
            m_perf_upd++;
            if (model_misp()) m_perf_misp++;
            i  = idx_of(bus.upd_pc);
            tk = bus.upd_taken || bus.upd_is_jump;
            if (m_valid[i] && m_tag[i] == tag_of(bus.upd_pc)) begin
                if (bus.upd_is_jump) m_cnt[i] = CMAX;
                else if (tk)         m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
                else                 m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                if (tk) m_tgt[i] = bus.upd_target;
            end else if (tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(bus.upd_pc);
                m_tgt[i]   = bus.upd_target;
                m_cnt[i]   = bus.upd_is_jump ? CMAX : CHALF;
            end
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef BPU_PERF_CNT_EN
        check({tag, "_perf_upd"},  {32'd0, bus.perf_updates},     64'(m_perf_upd));
        check({tag, "_perf_misp"}, {32'd0, bus.perf_mispredicts}, 64'(m_perf_misp));
`else
        check({tag, "_perf_upd"},  {32'd0, bus.perf_updates},     64'd0);
        check({tag, "_perf_misp"}, {32'd0, bus.perf_mispredicts}, 64'd0);
`endif
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        en, uv, jump, tk, ptk;
        logic [63:0] upc, utgt, uptgt, fpc;
        logic        ehit, etk;
        logic [63:0] etgt;
        logic        emisp;
        logic [63:0] eredir;
    } vec_t;

    function automatic vec_t mk(input logic en, uv, jump, tk, ptk,
                                input logic [63:0] upc, utgt, uptgt, fpc,
                                input logic ehit, etk, input logic [63:0] etgt,
                                input logic emisp, input logic [63:0] eredir);
        vec_t v;
        v.en = en; v.uv = uv; v.jump = jump; v.tk = tk; v.ptk = ptk;
        v.upc = upc; v.utgt = utgt; v.uptgt = uptgt; v.fpc = fpc;
        v.ehit = ehit; v.etk = etk; v.etgt = etgt; v.emisp = emisp; v.eredir = eredir;
        return v;
    endfunction

    task automatic drive(input logic en, uv, jump, tk, ptk,
                         input logic [63:0] upc, utgt, uptgt, fpc);
        enable              = en;
        bus.upd_valid       = uv;
        bus.upd_is_jump     = jump;
        bus.upd_taken       = tk;
        bus.upd_pred_taken  = ptk;
        bus.upd_pc          = upc;
        bus.upd_target      = utgt;
        bus.upd_pred_target = uptgt;
        bus.fetch_pc        = fpc;
    endtask

    vec_t vt [22];

    initial begin
        logic        h, t, rtk, rjump, ruv, ren, rptk;
        logic [63:0] g, rupc, rutgt, ruptgt, rfpc;

        vectors     = 0;
        miscompares = 0;
        model_reset();
        arst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h40);

        //          en uv jp tk ptk upc        utgt     uptgt  fetch              hit tk target  misp redirect
        vt[0]  = mk(1, 0, 0, 0, 0, 64'h0,     64'h0,   64'h0,  64'h40,            0, 0, 64'h44,   0, 64'h4);
        vt[1]  = mk(1, 1, 0, 1, 0, 64'h40,    64'h80,  64'h0,  64'h40,            0, 0, 64'h44,   1, 64'h80);
        vt[2]  = mk(1, 1, 0, 0, 1, 64'h40,    64'h0,   64'h80, 64'h40,            1, 1, 64'h80,   1, 64'h44);
        vt[3]  = mk(1, 1, 0, 0, 0, 64'h40,    64'h0,   64'h0,  64'h40,            1, 0, 64'h44,   0, 64'h44);
        vt[4]  = mk(1, 1, 0, 0, 0, 64'h40,    64'h0,   64'h0,  64'h40,            1, 0, 64'h44,   0, 64'h44);
        vt[5]  = mk(1, 0, 0, 0, 0, 64'h0,     64'h0,   64'h0,  64'h40,            1, 0, 64'h44,   0, 64'h4);
        vt[6]  = mk(1, 1, 0, 1, 0, 64'h40,    64'h80,  64'h0,  64'h40,            1, 0, 64'h44,   1, 64'h80);
        vt[7]  = mk(1, 0, 0, 0, 0, 64'h0,     64'h0,   64'h0,  64'h40,            1, 0, 64'h44,   0, 64'h4);
        vt[8]  = mk(1, 1, 0, 1, 0, 64'h4040,  64'h10,  64'h0,  64'h4040,          0, 0, 64'h4044, 1, 64'h10);
        vt[9]  = mk(1, 0, 0, 0, 0, 64'h0,     64'h0,   64'h0,  64'h4040,          1, 1, 64'h10,   0, 64'h4);
        vt[10] = mk(1, 0, 0, 0, 0, 64'h0,     64'h0,   64'h0,  64'h40,            0, 0, 64'h44,   0, 64'h4);
        vt[11] = mk(1, 1, 1, 1, 0, 64'h100,   64'h20,  64'h0,  64'h100,           0, 0, 64'h104,  1, 64'h20);
        vt[12] = mk(1, 1, 0, 0, 1, 64'h100,   64'h0,   64'h20, 64'h100,           1, 1, 64'h20,   1, 64'h104);
        vt[13] = mk(1, 0, 0, 0, 0, 64'h0,     64'h0,   64'h0,  64'h100,           1, 1, 64'h20,   0, 64'h4);
        vt[14] = mk(0, 1, 0, 1, 0, 64'h200,   64'h300, 64'h0,  64'h200,           0, 0, 64'h204,  1, 64'h300);
        vt[15] = mk(1, 0, 0, 0, 0, 64'h0,     64'h0,   64'h0,  64'h200,           0, 0, 64'h204,  0, 64'h4);
        vt[16] = mk(1, 1, 0, 1, 1, 64'h100,   64'h20,  64'h20, 64'h100,           1, 1, 64'h20,   0, 64'h20);
        vt[17] = mk(1, 1, 0, 1, 1, 64'h100,   64'h28,  64'h20, 64'h100,           1, 1, 64'h20,   1, 64'h28);
        vt[18] = mk(1, 0, 0, 1, 0, 64'h100,   64'h500, 64'h0,  64'h100,           1, 1, 64'h28,   0, 64'h500);
        vt[19] = mk(1, 0, 0, 0, 0, 64'h0,     64'h0,   64'h0,  64'h100,           1, 1, 64'h28,   0, 64'h4);
        vt[20] = mk(1, 0, 0, 0, 0, 64'h0,     64'h0,   64'h0,  64'hFFFFFFFFFFFFFFFC, 0, 0, 64'h0, 0, 64'h4);
        vt[21] = mk(1, 1, 0, 0, 0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 64'h40,    0, 0, 64'h44,   0, 64'h0);

        // Reset state while arst_n is held low
        #3;
        check("rst_hit",    64'(bus.pred_hit),   64'd0);
        check("rst_taken",  64'(bus.pred_taken), 64'd0);
        check("rst_target", bus.pred_target,     64'h44);
        check("rst_misp",   64'(bus.mispredict), 64'd0);
        check("rst_redir",  bus.redirect_pc,     64'h4);
        check_perf("rst");
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].en, vt[i].uv, vt[i].jump, vt[i].tk, vt[i].ptk,
                  vt[i].upc, vt[i].utgt, vt[i].uptgt, vt[i].fpc);
            @(negedge clk);
            check($sformatf("v%0d_hit", i),    64'(bus.pred_hit),   64'(vt[i].ehit));
            check($sformatf("v%0d_taken", i),  64'(bus.pred_taken), 64'(vt[i].etk));
            check($sformatf("v%0d_target", i), bus.pred_target,     vt[i].etgt);
            check($sformatf("v%0d_misp", i),   64'(bus.mispredict), 64'(vt[i].emisp));
            check($sformatf("v%0d_redir", i),  bus.redirect_pc,     vt[i].eredir);
            @(posedge clk);
            model_update();
            #1;
        end
        check_perf("table");

        // Asynchronous reset mid-run with a pending allocating update
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h300, 64'h999, 64'h0, 64'h100);
        #2;
        arst_n = 1'b0;
        #1;
        check("arst_hit_100", 64'(bus.pred_hit), 64'd0);
        check("arst_tgt_100", bus.pred_target,   64'h104);
        bus.fetch_pc = 64'h4040;
        #1;
        check("arst_hit_4040", 64'(bus.pred_hit), 64'd0);
        model_reset();
        check_perf("arst");
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        bus.upd_valid = 1'b0;
        bus.fetch_pc  = 64'h300;
        #1;
        check("arst_discard_300", 64'(bus.pred_hit), 64'd0);
        bus.fetch_pc = 64'h40;
        #1;
        check("arst_hit_40", 64'(bus.pred_hit), 64'd0);
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            ren   = ($urandom_range(7) != 0);
            ruv   = ($urandom_range(3) != 0);
            rjump = ($urandom_range(5) == 0);
            rtk   = rjump ? 1'b1 : 1'($urandom_range(1));
            rupc  = (64'($urandom_range(3)) << 8) | (64'($urandom_range(7)) << 2) | 64'($urandom_range(3));
            if ($urandom_range(15) == 0) rupc = rupc | ({32'($urandom), 32'h0} & 64'hFFFFFFFFFFFF0000);
            rutgt = 64'h1000 + 64'(4 * $urandom_range(15));
            model_predict(rupc, h, t, g);
            if ($urandom_range(3) != 0) begin
                rptk   = t;
                ruptgt = g;
            end else begin
                rptk   = 1'($urandom_range(1));
                ruptgt = 64'h1000 + 64'(4 * $urandom_range(15));
            end
            if ($urandom_range(1) == 0) rfpc = rupc;
            else rfpc = (64'($urandom_range(3)) << 8) | (64'($urandom_range(7)) << 2);
            drive(ren, ruv, rjump, rtk, rptk, rupc, rutgt, ruptgt, rfpc);
            @(negedge clk);
            model_predict(rfpc, h, t, g);
            check("rnd_hit",    64'(bus.pred_hit),   64'(h));
            check("rnd_taken",  64'(bus.pred_taken), 64'(t));
            check("rnd_target", bus.pred_target,     g);
            check("rnd_misp",   64'(bus.mispredict), 64'(model_misp()));
            check("rnd_redir",  bus.redirect_pc,     rtk ? rutgt : rupc + 64'd4);
            @(posedge clk);
            model_update();
            #1;
        end
        check_perf("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised dynamic branch predictor: direct-mapped branch history table (BHT) of saturating counters plus branch target buffer (BTB).
- Lookup side sits in IF beside the instruction memory. It gives a predicted next PC in the same cycle as current_pc.
- Update side sits in ID, where branches and jumps resolve. It reports mispredicts and the corrected redirect PC so the core can flush IF/ID.
- Replaces the static "predict not-taken, flush on taken" scheme.

Parameters:
- DATA_W, 64, PC and target width.
- ENTRIES, 64, number of BHT/BTB entries; must be a power of 2, min 4. IDX_W = log2(ENTRIES).
- CNT_W, 2, saturating counter width; 1..4.
- TAG_W, 8, BTB tag width; IDX_W+TAG_W+2 <= DATA_W.

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- enable  in  1  global run enable; when 0, no state changes
- fetch_pc  in  DATA_W  IF-stage PC to predict
- pred_hit  out  1  valid BTB entry with matching tag
- pred_taken  out  1  predicted taken
- pred_target  out  DATA_W  predicted next PC
- upd_valid  in  1  ID stage holds a resolved branch or jump this cycle
- upd_pc  in  DATA_W  PC of the resolved instruction
- upd_is_jump  in  1  unconditional jump
- upd_taken  in  1  actual outcome (forced 1 for jumps)
- upd_target  in  DATA_W  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipe for this instruction
- upd_pred_target  in  DATA_W  predicted target carried down the pipe
- mispredict  out  1  flush request
- redirect_pc  out  DATA_W  corrected fetch PC when mispredict=1
- perf_updates  out  32  see Optional Feature
- perf_mispredicts  out  32  see Optional Feature

Behaviour:
- Address decomposition:
  - index = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] ignored.
- Entry contents: valid bit, tag, target, counter.
  - Valid bits and counters are flops, reset asynchronously: valid=0, counter = 2^(CNT_W-1)-1 (weakly not-taken).
  - Tag and target storage need no reset.
- Lookup is combinational, zero latency.
  - pred_hit = valid[index] && tag match.
  - pred_taken = pred_hit && counter MSB.
  - pred_target = pred_taken ? stored target : fetch_pc+4. Addition is modulo 2^DATA_W.
- Reset values: pred_hit=0, pred_taken=0, pred_target=fetch_pc+4, mispredict=0, redirect_pc=upd_pc+4, perf counters 0.
- Mispredict is combinational from the update inputs and gated by upd_valid.
  - mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - mispredict does not depend on enable.
- Update occurs on the rising clk edge when enable && upd_valid; it is visible to lookups the next cycle.
  - Tag hit: counter increments on taken (saturating at 2^CNT_W-1) or decrements on not-taken (saturating at 0). Target is rewritten on taken.
  - Tag miss or invalid, taken: allocate the entry (valid=1, new tag, target). Counter = 2^(CNT_W-1), weakly taken.
  - Tag miss or invalid, not-taken: no change.
  - upd_is_jump: counter forced to 2^CNT_W-1 on hit or allocate.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents; there is no bypass.
- enable=0: arrays frozen, lookup still live.
- arst_n asserted mid-operation: all valids clear immediately; the pending update is discarded.

Optional Feature:
- Macro BPU_PERF_CNT_EN.
- Defined:
  - perf_updates increments on every enable && upd_valid cycle.
  - perf_mispredicts increments when mispredict && enable.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: both outputs tied to 0, and no counter flops exist.

Test Plan (ENTRIES=64, CNT_W=2, TAG_W=8):
1. Reset, fetch_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44, mispredict=0.
2. Update pc=0x40, taken, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80 that cycle. Next cycle fetch_pc=0x40 -> pred_hit=1, pred_taken=1, pred_target=0x80.
3. After (2), three not-taken updates at 0x40 -> counter 2→1→0→0 (saturates). pred_taken=0 after the first; the first reports mispredict=1, redirect_pc=0x44.
4. After (2), fetch_pc=0x4040 (same index 16, different tag) -> pred_hit=0, pred_target=0x4044. Taken update at 0x4040, target 0x10 -> replaces the entry; fetch 0x40 now misses.
5. Jump update pc=0x100, target=0x20 -> next cycle fetch 0x100 gives pred_taken=1, pred_target=0x20. One not-taken update leaves pred_taken=1 (counter 3→2).
6. enable=0 with a taken update at 0x200 -> mispredict=1 but no allocation (fetch 0x200 misses). Then pulse arst_n low mid-run -> all lookups miss. With BPU_PERF_CNT_EN, the perf counters read 0 after the reset pulse.
